// File: rtl/funprof_pkg.sv
// Shared definitions for the function-profiler sequencing controller.
package funprof_pkg;

  localparam int unsigned FUNPROF_ADDR_W  = 32;
  localparam int unsigned FUNPROF_CNT_W   = 32;
  localparam int unsigned FUNPROF_DEPTH_W = 4;

  // Encoding is visible on the state port, so values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_IN_FUNC = 2'd2,
    ST_HALTED  = 2'd3
  } state_e;

endpackage

// File: rtl/funprof_call_timer.sv
// Saturating per-call cycle timer plus longest-call register.
// Only instantiated when FUNPROF_MAX_EN is defined.
module funprof_call_timer #(
  parameter int unsigned CntW = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            clr_i,     // wipe timer and max
  input  logic            zero_i,    // restart timer (call entry or stop)
  input  logic            run_i,     // controller is inside the function
  input  logic            done_i,    // outermost call ends this cycle
  output logic [CntW-1:0] max_cycles_o
);

  logic [CntW-1:0] timer_q, timer_d;
  logic [CntW-1:0] max_q, max_d;
  logic [CntW-1:0] dur;

  // The ending exit cycle is itself inside the call, hence timer + 1.
  assign dur = (timer_q == '1) ? timer_q : timer_q + CntW'(1);

  // Next-state for timer and longest-call register.
  always_comb begin
    timer_d = timer_q;
    max_d   = max_q;
    if (clr_i || zero_i) begin
      timer_d = '0;
    end else if (run_i && timer_q != '1) begin
      timer_d = timer_q + CntW'(1);
    end
    if (clr_i) begin
      max_d = '0;
    end else if (done_i && dur > max_q) begin
      max_d = dur;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      timer_q <= '0;
      max_q   <= '0;
    end else begin
      timer_q <= timer_d;
      max_q   <= max_d;
    end
  end

  assign max_cycles_o = max_q;

endmodule

// File: rtl/funprof_ctrl.sv
// Sequencing controller for the function profiler cycle counter.
// Optional feature: define FUNPROF_MAX_EN to build the longest-call timer.
module funprof_ctrl
  import funprof_pkg::*;
#(
  parameter int unsigned ADDR_W  = FUNPROF_ADDR_W,
  parameter int unsigned CNT_W   = FUNPROF_CNT_W,
  parameter int unsigned DEPTH_W = FUNPROF_DEPTH_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic [ADDR_W-1:0]  entry_addr,
  input  logic [ADDR_W-1:0]  exit_addr,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               pc_valid,
  output logic               cnt_enable,
  output logic               cnt_reset,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   call_count,
  output logic [DEPTH_W-1:0] depth,
  output logic [CNT_W-1:0]   max_cycles,
  output logic               overflow
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   call_count_q, call_count_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               overflow_q, overflow_d;
  logic               cnt_reset_q, cnt_reset_d;

  logic entry_hit, exit_hit;
  logic stop_acc, start_acc, cmd_acc, wipe;

  assign entry_hit = pc_valid && (pc == entry_addr);
  assign exit_hit  = pc_valid && (pc == exit_addr);

  // Commands that are ignored in the current state do not block PC events.
  assign stop_acc  = stop  && (state_q == ST_ARMED || state_q == ST_IN_FUNC);
  assign start_acc = start && (state_q == ST_IDLE  || state_q == ST_HALTED);
  assign cmd_acc   = clear || stop_acc || start_acc;
  assign wipe      = clear || (start_acc && state_q == ST_IDLE);

  // Next-state: commands by priority, then PC events.
  always_comb begin
    state_d      = state_q;
    call_count_d = call_count_q;
    depth_d      = depth_q;
    overflow_d   = overflow_q;
    cnt_reset_d  = 1'b0;
    if (wipe) begin
      state_d      = clear ? ST_IDLE : ST_ARMED;
      call_count_d = '0;
      depth_d      = '0;
      overflow_d   = 1'b0;
      cnt_reset_d  = 1'b1;
    end else if (stop_acc) begin
      state_d = ST_HALTED;
      depth_d = '0;
    end else if (start_acc) begin
      state_d = ST_ARMED;  // resume from HALTED, stats kept
    end else begin
      unique case (state_q)
        ST_ARMED: begin
          if (entry_hit) begin
            state_d = ST_IN_FUNC;
            depth_d = DEPTH_W'(1);
            if (call_count_q == '1) overflow_d   = 1'b1;
            else                    call_count_d = call_count_q + CNT_W'(1);
          end
        end
        ST_IN_FUNC: begin
          // Exit takes precedence so entry_addr == exit_addr acts as an exit.
          if (exit_hit) begin
            if (depth_q > DEPTH_W'(1)) begin
              depth_d = depth_q - DEPTH_W'(1);
            end else begin
              depth_d = '0;
              state_d = ST_ARMED;
            end
          end else if (entry_hit) begin
            if (depth_q == '1) overflow_d = 1'b1;
            else               depth_d    = depth_q + DEPTH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      call_count_q <= '0;
      depth_q      <= '0;
      overflow_q   <= 1'b0;
      cnt_reset_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      call_count_q <= call_count_d;
      depth_q      <= depth_d;
      overflow_q   <= overflow_d;
      cnt_reset_q  <= cnt_reset_d;
    end
  end

`ifdef FUNPROF_MAX_EN
  logic timer_zero, timer_run, call_done;

  assign timer_zero = stop_acc || (!cmd_acc && state_q == ST_ARMED && entry_hit);
  assign timer_run  = !cmd_acc && state_q == ST_IN_FUNC;
  assign call_done  = timer_run && exit_hit && depth_q <= DEPTH_W'(1);

  funprof_call_timer #(
    .CntW (CNT_W)
  ) u_call_timer (
    .clk_i        (clk),
    .reset_i      (reset),
    .clr_i        (wipe),
    .zero_i       (timer_zero),
    .run_i        (timer_run),
    .done_i       (call_done),
    .max_cycles_o (max_cycles)
  );
`else
  assign max_cycles = '0;
`endif

  assign cnt_enable = (state_q == ST_IN_FUNC);
  assign cnt_reset  = cnt_reset_q;
  assign state      = state_q;
  assign call_count = call_count_q;
  assign depth      = depth_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/funprof_ctrl.md
# funprof_ctrl

Sequencing controller for the function profiler's 32-bit cycle counter. It watches the processor program-counter stream for a programmed function entry and exit address. It drives the counter's `enable` and `reset` so that only cycles spent inside the target function (including nested or recursive calls) are counted. It also tracks call count, nesting depth and the longest single outermost call, and sits between the PC tap and the counter instance in the profiler core.

## Interface
- `ADDR_W`, 32: PC and address width.
- `CNT_W`, 32: width of call count and per-call timer.
- `DEPTH_W`, 4: nesting-depth counter width.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: arm command, single-cycle pulse.
- `stop` in 1: halt command, single-cycle pulse.
- `clear` in 1: clear-all command, single-cycle pulse.
- `entry_addr` in ADDR_W: function entry address. Software holds it stable while armed.
- `exit_addr` in ADDR_W: function return-site address. Software holds it stable while armed.
- `pc` in ADDR_W: executed-instruction address.
- `pc_valid` in 1: `pc` is valid this cycle.
- `cnt_enable` out 1: drives the counter's `enable`.
- `cnt_reset` out 1: drives the counter's `reset`.
- `state` out 2: current FSM state.
- `call_count` out CNT_W: outermost entries seen.
- `depth` out DEPTH_W: current nesting depth.
- `max_cycles` out CNT_W: longest outermost call, in cycles.
- `overflow` out 1: sticky saturation flag.

## Operation
- States (encoding): IDLE=0, ARMED=1, IN_FUNC=2, HALTED=3.
- Command priority: clear > stop > start > PC events.
- Entry hit: `pc_valid && pc==entry_addr`. Exit hit: `pc_valid && pc==exit_addr`.
- clear, from any state:
  - next state IDLE.
  - `call_count`, `depth`, `max_cycles`, `overflow` and the call timer go to 0.
  - `cnt_reset`=1 for exactly one cycle.
- IDLE + start:
  - next state ARMED.
  - Same clearing and `cnt_reset` pulse as clear.
- HALTED + start: next state ARMED with no clearing (resume).
- ARMED or IN_FUNC + stop: next state HALTED. `depth` and the call timer go to 0.
- start in ARMED or IN_FUNC: ignored. stop in IDLE or HALTED: ignored.
- ARMED + entry hit:
  - next state IN_FUNC, `depth` becomes 1, call timer goes to 0.
  - `call_count` increments and saturates at all-ones. Saturation sets `overflow`.
- IN_FUNC + entry hit (nested call): `depth` increments.
  - At all-ones, `depth` holds and `overflow` is set.
- IN_FUNC + exit hit, `depth`>1: `depth` decrements.
- IN_FUNC + exit hit, `depth`==1: `depth` becomes 0 and next state is ARMED. The call ends.
- `entry_addr==exit_addr`:
  - in ARMED, a match is treated as an entry;
  - in IN_FUNC, a match is treated as an exit only (no depth increment).
- Call timer:
  - increments every IN_FUNC cycle, saturating.
  - At the ending exit cycle, duration = timer+1.
  - `max_cycles` loads the duration if it is greater (unsigned compare).
- `cnt_enable` = (`state`==IN_FUNC), a pure Moore output.
- The external counter wraps per its own rules. This block does not track that wrap.

## Timing
- Reset values: `state`=IDLE, `cnt_enable`=0, `cnt_reset`=0, `call_count`=0, `depth`=0, `max_cycles`=0, `overflow`=0.
- `reset` does not drive `cnt_reset`. The top level ORs `reset` into the counter reset.
- Entry hit in cycle T: `state`=IN_FUNC and `cnt_enable`=1 from T+1.
- Ending exit hit in cycle E: `cnt_enable`=0 from E+1. The counter gains exactly E−T per call.
- `call_count`, `depth` and `max_cycles` update at the edge ending the cycle of the event, so they are visible the next cycle.
- `cnt_reset` is high in the cycle after clear/start is sampled; `cnt_enable` is 0 in that cycle.
- A PC hit in the same cycle as any accepted command is ignored.

## Configuration
- `FUNPROF_MAX_EN` defined: call timer and max-duration compare are built; `max_cycles` behaves as above.
- `FUNPROF_MAX_EN` undefined: no timer or compare logic; `max_cycles` tied to 0, port kept.

## Structure
- Package `funprof_pkg` holds:
  - state encoding constants `ST_IDLE`, `ST_ARMED`, `ST_IN_FUNC`, `ST_HALTED`;
  - default widths `FUNPROF_ADDR_W`, `FUNPROF_CNT_W`, `FUNPROF_DEPTH_W`.
- Sub-module `funprof_call_timer` holds the saturating per-call timer plus the max register and compare. It is instantiated only under `FUNPROF_MAX_EN`.

## Test plan
- **Basic call:**
  - Stimulus: reset; start; entry hit at cycle 10; exit hit at cycle 25.
  - Required: `cnt_enable` high on cycles 11–25, counter=15, `call_count`=1, `max_cycles`=15, `state`=ARMED at cycle 26.
- **Recursion:**
  - Stimulus: entry at cycles 5, 8, 12; exits at 20, 22, 30.
  - Required: `depth` peaks at 3; `cnt_enable` high on cycles 6–30; counter=25; `call_count`=1.
- **Stop/resume:**
  - Stimulus: stop mid-call at depth 2; later start; entry at 100; exit at 104.
  - Required: `state`=HALTED and `cnt_enable`=0 after stop; after resume, counter rises by 4 and `call_count` rises by 1, earlier values kept.
- **Priority:**
  - Stimulus: clear and stop asserted in the same cycle as an entry hit while ARMED.
  - Required: `state`=IDLE, all stats 0, `cnt_reset` pulses once, `call_count` stays 0.
- **Saturation:**
  - Stimulus: `DEPTH_W`=2, four nested entries.
  - Required: `depth` holds at 3 and `overflow`=1 until clear.
- **Macro off:**
  - Stimulus: basic call scenario with `FUNPROF_MAX_EN` undefined.
  - Required: `max_cycles`=0 throughout; all other outputs identical to the basic call.
